// File: rtl/apb_master_q.sv
// APB4 master for the register-debug path: queued commands in, one APB transfer
// per command, one response out. Handles wait states, pslverr and timeouts.
module apb_master_q #(
    parameter int ADDRW   = 32,
    parameter int DATAW   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRW-1:0]         cmd_addr,
    input  logic [DATAW-1:0]         cmd_wdata,
    input  logic [DATAW/8-1:0]       cmd_strb,
    output logic [$clog2(DEPTH):0]   cmd_count,
    output logic                     busy,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATAW-1:0]         rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    output logic                     rsp_write,
    output logic [ADDRW-1:0]         paddr,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [DATAW-1:0]         pwdata,
    output logic [DATAW/8-1:0]       pstrb,
    input  logic [DATAW-1:0]         prdata,
    input  logic                     pready,
    input  logic                     pslverr
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = DATAW / 8;
    localparam int EW = 1 + ADDRW + DATAW + SW;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   ONE_CNT  = (PW+1)'(1);
    localparam logic [PW-1:0] ONE_PTR  = PW'(1);
    localparam logic [WW-1:0] ONE_W    = WW'(1);
    localparam logic [WW-1:0] WLAST    = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]     state;
    logic [WW-1:0]  wait_cnt;
    logic [EW-1:0]  fifo_mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic           timeout_hit;

    logic              head_write;
    logic [ADDRW-1:0]  head_addr;
    logic [DATAW-1:0]  head_wdata;
    logic [SW-1:0]     head_strb;

    assign cmd_ready   = (cmd_count != FULL_CNT);
    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state == S_IDLE) && (cmd_count != '0) && (!rsp_valid || rsp_ready);
    assign busy        = (cmd_count != '0) || (state != S_IDLE) || rsp_valid;
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WLAST);

    assign {head_write, head_addr, head_wdata, head_strb} = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb};
        end
    end

    // Pointers wrap for free since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE_PTR;
            if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
            case ({push, pop})
                2'b10:   cmd_count <= cmd_count + ONE_CNT;
                2'b01:   cmd_count <= cmd_count - ONE_CNT;
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_write   <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state    <= S_SETUP;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        paddr    <= head_addr;
                        pwrite   <= head_write;
                        pwdata   <= head_wdata;
                        pstrb    <= head_write ? head_strb : '0;
                        wait_cnt <= '0;
                    end
                end
                S_SETUP: begin
                    state   <= S_ACCESS;
                    penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (pready) begin
                        state       <= S_IDLE;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_write   <= pwrite;
                    end else if (timeout_hit) begin
                        state       <= S_IDLE;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_write   <= pwrite;
                    end else begin
                        wait_cnt <= wait_cnt + ONE_W;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule
